// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, FSM state and the
// per-access context carried across a split transfer or into the response.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZ_B = 2'd0,
        SIZ_H = 2'd1,
        SIZ_W = 2'd2
    } siz_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    typedef struct packed {
        siz_e       siz;
        logic       uns;
        logic       wen;
        logic [1:0] o;
    } acc_t;

    typedef struct packed {
        siz_e       siz;
        logic       uns;
        logic [1:0] o;
        logic       split;
    } rsp_t;

    // Encoding 3 is reserved and behaves as a word access.
    function automatic siz_e siz_dec(input logic [1:0] s);
        return (s == 2'd3) ? SIZ_W : siz_e'(s);
    endfunction

    function automatic logic [3:0] lane_mask(input siz_e s);
        case (s)
            SIZ_B:   return 4'b0001;
            SIZ_H:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load data alignment: rotates the {second, first} word pair down to the
// addressed byte and applies sign/zero extension.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] lo,
    input  logic [DW-1:0] hi,
    input  logic [1:0]    o,
    input  siz_e          siz,
    input  logic          uns,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] sh;

    // Unsplit loads feed the same word on both halves, so this is a rotate.
    assign sh = DW'({hi, lo} >> {o, 3'b000});

    always_comb begin
        dout = sh;
        case (siz)
            SIZ_B:   dout = {{(DW-8){~uns & sh[7]}}, sh[7:0]};
            SIZ_H:   dout = {{(DW-16){~uns & sh[15]}}, sh[15:0]};
            default: dout = sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: maps byte/half/word CPU accesses onto a word-wide memory
// port, splitting accesses that cross a word boundary into two transfers.
module lsu
    import lsu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ls_req,
    input  logic          ls_wen,
    input  logic [1:0]    ls_siz,
    input  logic          ls_uns,
    input  logic [AW-1:0] ls_adr,
    input  logic [DW-1:0] ls_wdt,
    output logic          ls_ack,
    output logic          ls_vld,
    output logic [DW-1:0] ls_rdt,
    output logic          req,
    output logic          wen,
    output logic [3:0]    sel,
    output logic [AW-1:0] adr,
    output logic [DW-1:0] wdt,
    input  logic [DW-1:0] rdt,
    input  logic          ack
);

    state_e          state;
    acc_t            sp;
    logic [AW-1:0]   sp_wadr;
    logic [DW-1:0]   sp_wdt;
    rsp_t            rsp;
    logic [DW-1:0]   rdt_lo;
    logic            cap;
    logic [DW-1:0]   held;

    siz_e            in_siz;
    logic [1:0]      in_o;
    logic            in_split;
    logic [7:0]      sel_wide;
    logic [2*DW-1:0] wdt_wide;
    logic [AW-1:0]   in_wadr;
    logic            first_acc;
    rsp_t            rsp_next;
    logic [DW-1:0]   ext_lo;
    logic [DW-1:0]   ext_out;

    assign in_siz   = siz_dec(ls_siz);
    assign in_o     = ls_adr[1:0];
    assign in_split = (in_siz == SIZ_H && in_o == 2'd3) || (in_siz == SIZ_W && in_o != 2'd0);
    assign sel_wide = {4'b0000, lane_mask(in_siz)} << in_o;
    assign wdt_wide = {ls_wdt, ls_wdt} << {in_o, 3'b000};
    assign in_wadr  = {ls_adr[AW-1:2], 2'b00};

    assign first_acc = (state == IDLE) && ls_req && ack && in_split;
    assign rsp_next  = (state == SPLIT) ? '{siz: sp.siz, uns: sp.uns, o: sp.o, split: 1'b1}
                                        : '{siz: in_siz, uns: ls_uns, o: in_o, split: 1'b0};

    // Memory request; reset forces the handshake outputs low.
    always_comb begin
        req    = 1'b0;
        ls_ack = 1'b0;
        wen    = ls_wen;
        adr    = in_wadr;
        sel    = sel_wide[3:0];
        wdt    = wdt_wide[2*DW-1:DW];
        if (state == SPLIT) begin
            req    = rst;
            ls_ack = rst & ack;
            wen    = sp.wen;
            adr    = sp_wadr + AW'(4);
            sel    = (sp.siz == SIZ_W) ? (4'hF >> (3'd4 - {1'b0, sp.o})) : 4'b0001;
            wdt    = sp_wdt;
        end else begin
            req    = rst & ls_req;
            ls_ack = rst & ls_req & ack & ~in_split;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sp      <= '0;
            sp_wadr <= '0;
            sp_wdt  <= '0;
            rsp     <= '0;
            rdt_lo  <= '0;
            cap     <= 1'b0;
            ls_vld  <= 1'b0;
            held    <= '0;
        end else begin
            ls_vld <= ls_ack & ~wen;
            cap    <= first_acc & ~ls_wen;
            if (ls_ack && !wen) rsp <= rsp_next;
            // First-transfer read data is only valid the cycle after its accept.
            if (cap) rdt_lo <= rdt;
            if (ls_vld) held <= ext_out;
            case (state)
                IDLE: if (first_acc) begin
                    state   <= SPLIT;
                    sp      <= '{siz: in_siz, uns: ls_uns, wen: ls_wen, o: in_o};
                    sp_wadr <= in_wadr;
                    sp_wdt  <= wdt_wide[2*DW-1:DW];
                end
                SPLIT: if (ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ext_lo = rsp.split ? rdt_lo : rdt;

    lsu_ext #(.DW(DW)) u_ext (
        .lo   (ext_lo),
        .hi   (rdt),
        .o    (rsp.o),
        .siz  (rsp.siz),
        .uns  (rsp.uns),
        .dout (ext_out)
    );

    assign ls_rdt = ls_vld ? ext_out : held;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a table of single-transfer accesses plus hand
// sequences for split, stall, reset-in-split and back-to-back loads.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_req, ls_wen, ls_uns;
    logic [1:0]  ls_siz;
    logic [11:0] ls_adr;
    logic [31:0] ls_wdt;
    logic        ls_ack, ls_vld;
    logic [31:0] ls_rdt;
    logic        req, wen;
    logic [3:0]  sel;
    logic [11:0] adr;
    logic [31:0] wdt;
    logic [31:0] rdt;
    logic        ack;
    logic        ack_en;

    int checks = 0;
    int errors = 0;

    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx;
    logic [31:0] pl_dat;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;
    assign ack = ack_en;

    lsu #(.DW(32), .AW(12)) dut (
        .clk(clk), .rst(rst),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_siz(ls_siz), .ls_uns(ls_uns),
        .ls_adr(ls_adr), .ls_wdt(ls_wdt),
        .ls_ack(ls_ack), .ls_vld(ls_vld), .ls_rdt(ls_rdt),
        .req(req), .wen(wen), .sel(sel), .adr(adr), .wdt(wdt),
        .rdt(rdt), .ack(ack)
    );

    // Memory model: one-cycle read latency, garbage on rdt when no read returns.
    always @(posedge clk) begin
        if (req && ack && !wen) rdt <= mem[adr[11:2]];
        else                    rdt <= 32'hDEADBEEF;
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (req && ack && wen)
            for (int i = 0; i < 4; i++)
                if (sel[i]) mem[adr[11:2]][8*i +: 8] <= wdt[8*i +: 8];
    end

    typedef struct {
        logic        wen;
        logic [1:0]  siz;
        logic        uns;
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  esel;
        logic [11:0] eadr;
        logic [31:0] ewdt;
        logic [31:0] erd;
    } vec_t;

    vec_t v [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic setreq(input logic w, input logic [1:0] s, input logic u,
                          input logic [11:0] a, input logic [31:0] d);
        ls_req = 1'b1; ls_wen = w; ls_siz = s; ls_uns = u; ls_adr = a; ls_wdt = d;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        pl_idx = idx; pl_dat = d; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 2'd2, 1'b0, 12'h004, 32'h12345678, 4'hF, 12'h004, 32'h12345678, 32'h0};
        v[1]  = '{1'b0, 2'd2, 1'b0, 12'h004, 32'h0,        4'hF, 12'h004, 32'h0, 32'h12345678};
        v[2]  = '{1'b1, 2'd2, 1'b0, 12'h008, 32'h80FF7F01, 4'hF, 12'h008, 32'h80FF7F01, 32'h0};
        v[3]  = '{1'b0, 2'd0, 1'b0, 12'h00A, 32'h0,        4'h4, 12'h008, 32'h0, 32'hFFFFFFFF};
        v[4]  = '{1'b0, 2'd0, 1'b1, 12'h00A, 32'h0,        4'h4, 12'h008, 32'h0, 32'h000000FF};
        v[5]  = '{1'b0, 2'd1, 1'b0, 12'h009, 32'h0,        4'h6, 12'h008, 32'h0, 32'hFFFFFF7F};
        v[6]  = '{1'b1, 2'd0, 1'b0, 12'h003, 32'hFFFFFFAB, 4'h8, 12'h000, 32'hABFFFFFF, 32'h0};
        v[7]  = '{1'b0, 2'd0, 1'b1, 12'h003, 32'h0,        4'h8, 12'h000, 32'h0, 32'h000000AB};
        v[8]  = '{1'b1, 2'd1, 1'b0, 12'h006, 32'h1234BEEF, 4'hC, 12'h004, 32'hBEEF1234, 32'h0};
        v[9]  = '{1'b0, 2'd2, 1'b0, 12'h004, 32'h0,        4'hF, 12'h004, 32'h0, 32'hBEEF5678};
        v[10] = '{1'b0, 2'd1, 1'b0, 12'h006, 32'h0,        4'hC, 12'h004, 32'h0, 32'hFFFFBEEF};
        v[11] = '{1'b0, 2'd1, 1'b1, 12'h006, 32'h0,        4'hC, 12'h004, 32'h0, 32'h0000BEEF};
        v[12] = '{1'b0, 2'd3, 1'b0, 12'h004, 32'h0,        4'hF, 12'h004, 32'h0, 32'hBEEF5678};
        v[13] = '{1'b0, 2'd0, 1'b0, 12'h009, 32'h0,        4'h2, 12'h008, 32'h0, 32'h0000007F};
        v[14] = '{1'b0, 2'd1, 1'b0, 12'h00A, 32'h0,        4'hC, 12'h008, 32'h0, 32'hFFFF80FF};

        // Reset with a request pending: everything must stay quiet.
        rst = 1'b0; ack_en = 1'b1;
        setreq(1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
        preload(10'h3FF, 32'h2211CAFE);
        preload(10'h000, 32'hDEAD4433);
        #1;
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_ls_ack", {31'b0, ls_ack}, 32'd0);
        chk("rst_ls_vld", {31'b0, ls_vld}, 32'd0);
        chk("rst_ls_rdt", ls_rdt, 32'h0);
        tick();
        rst = 1'b1; ls_req = 1'b0;

        for (int i = 0; i < 15; i++) begin
            tick();
            setreq(v[i].wen, v[i].siz, v[i].uns, v[i].a, v[i].wd);
            #1;
            chk("tbl_ls_ack", {31'b0, ls_ack}, 32'd1);
            chk("tbl_sel", {28'b0, sel}, {28'b0, v[i].esel});
            chk("tbl_adr", {20'b0, adr}, {20'b0, v[i].eadr});
            if (v[i].wen) chk("tbl_wdt", wdt, v[i].ewdt);
            tick();
            ls_req = 1'b0;
            #1;
            chk("tbl_ls_vld", {31'b0, ls_vld}, {31'b0, ~v[i].wen});
            if (!v[i].wen) chk("tbl_ls_rdt", ls_rdt, v[i].erd);
        end

        // Split word store @0x00D, then read it back.
        tick();
        setreq(1'b1, 2'd2, 1'b0, 12'h00D, 32'hAABBCCDD);
        #1;
        chk("sst1_ls_ack", {31'b0, ls_ack}, 32'd0);
        chk("sst1_adr", {20'b0, adr}, 32'h00C);
        chk("sst1_sel", {28'b0, sel}, 32'hE);
        chk("sst1_wdt", wdt & 32'hFFFFFF00, 32'hBBCCDD00);
        tick(); #1;
        chk("sst2_ls_ack", {31'b0, ls_ack}, 32'd1);
        chk("sst2_req", {31'b0, req}, 32'd1);
        chk("sst2_adr", {20'b0, adr}, 32'h010);
        chk("sst2_sel", {28'b0, sel}, 32'h1);
        chk("sst2_wdt", {24'b0, wdt[7:0]}, 32'hAA);
        tick();
        ls_req = 1'b0;
        #1;
        chk("sst_no_vld", {31'b0, ls_vld}, 32'd0);
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'h00D, 32'h0);
        #1;
        chk("sld1_ls_ack", {31'b0, ls_ack}, 32'd0);
        tick(); #1;
        chk("sld2_ls_ack", {31'b0, ls_ack}, 32'd1);
        tick();
        ls_req = 1'b0;
        #1;
        chk("sld_vld", {31'b0, ls_vld}, 32'd1);
        chk("sld_rdt", ls_rdt, 32'hAABBCCDD);

        // Split word load wrapping from the last word to word 0.
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'hFFE, 32'h0);
        #1;
        chk("wrap1_ls_ack", {31'b0, ls_ack}, 32'd0);
        chk("wrap1_adr", {20'b0, adr}, 32'hFFC);
        chk("wrap1_sel", {28'b0, sel}, 32'hC);
        tick(); #1;
        chk("wrap2_adr", {20'b0, adr}, 32'h000);
        chk("wrap2_sel", {28'b0, sel}, 32'h3);
        chk("wrap2_ls_ack", {31'b0, ls_ack}, 32'd1);
        tick();
        ls_req = 1'b0;
        #1;
        chk("wrap_vld", {31'b0, ls_vld}, 32'd1);
        chk("wrap_rdt", ls_rdt, 32'h44332211);

        // Memory stalls the second transfer for three cycles.
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'h00D, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            ack_en = 1'b0;
            #1;
            chk("stall_ls_ack", {31'b0, ls_ack}, 32'd0);
            chk("stall_req", {31'b0, req}, 32'd1);
            chk("stall_adr", {20'b0, adr}, 32'h010);
            chk("stall_vld", {31'b0, ls_vld}, 32'd0);
            chk("stall_rdt_hold", ls_rdt, 32'h44332211);
        end
        tick();
        ack_en = 1'b1;
        #1;
        chk("stall_end_ls_ack", {31'b0, ls_ack}, 32'd1);
        tick();
        ls_req = 1'b0;
        #1;
        chk("stall_vld_end", {31'b0, ls_vld}, 32'd1);
        chk("stall_rdt_end", ls_rdt, 32'hAABBCCDD);

        // Reset pulsed in the middle of a split load.
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'h00D, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rsplit_req", {31'b0, req}, 32'd0);
        chk("rsplit_ls_ack", {31'b0, ls_ack}, 32'd0);
        chk("rsplit_vld", {31'b0, ls_vld}, 32'd0);
        chk("rsplit_rdt", ls_rdt, 32'h0);
        tick();
        rst = 1'b1; ls_req = 1'b0;
        #1;
        chk("rsplit_vld_a", {31'b0, ls_vld}, 32'd0);
        tick(); #1;
        chk("rsplit_vld_b", {31'b0, ls_vld}, 32'd0);
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
        #1;
        chk("rsplit_idle_ack", {31'b0, ls_ack}, 32'd1);
        chk("rsplit_idle_adr", {20'b0, adr}, 32'h004);
        tick();
        ls_req = 1'b0;
        #1;
        chk("rsplit_idle_vld", {31'b0, ls_vld}, 32'd1);
        chk("rsplit_idle_rdt", ls_rdt, 32'hBEEF5678);

        // Back-to-back loads with no bubble.
        tick();
        setreq(1'b0, 2'd2, 1'b0, 12'h000, 32'h0);
        #1;
        chk("b2b0_ls_ack", {31'b0, ls_ack}, 32'd1);
        tick();
        ls_adr = 12'h004;
        #1;
        chk("b2b1_ls_ack", {31'b0, ls_ack}, 32'd1);
        chk("b2b1_vld", {31'b0, ls_vld}, 32'd1);
        chk("b2b1_rdt", ls_rdt, 32'hABAD4433);
        tick();
        ls_adr = 12'h008;
        #1;
        chk("b2b2_ls_ack", {31'b0, ls_ack}, 32'd1);
        chk("b2b2_vld", {31'b0, ls_vld}, 32'd1);
        chk("b2b2_rdt", ls_rdt, 32'hBEEF5678);
        tick();
        ls_req = 1'b0;
        #1;
        chk("b2b3_vld", {31'b0, ls_vld}, 32'd1);
        chk("b2b3_rdt", ls_rdt, 32'h80FF7F01);
        tick(); #1;
        chk("b2b4_vld", {31'b0, ls_vld}, 32'd0);
        chk("b2b4_rdt_hold", ls_rdt, 32'h80FF7F01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DW, default 32, data width in bits; only 32 is supported.
REQ-002 Parameter AW, default 12, byte address width (4 KiB memory).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ls_req  input  1  CPU load/store request.
REQ-006 ls_wen  input  1  1 = store, 0 = load.
REQ-007 ls_siz  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
REQ-008 ls_uns  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 ls_adr  input  AW  byte address.
REQ-010 ls_wdt  input  DW  store data, right-aligned.
REQ-011 ls_ack  output  1  request accepted this cycle.
REQ-012 ls_vld  output  1  load data valid.
REQ-013 ls_rdt  output  DW  load data, right-aligned and extended.
REQ-014 req/wen/sel[4]/adr[AW]/wdt[DW]  output  memory request, write enable, byte lanes, word-aligned address, lane-placed write data.
REQ-015 rdt  input  DW  memory read data; ack  input  1  memory accept.

Function
REQ-016 The memory port SHALL have one-cycle read latency: rdt is valid the cycle after the read request is accepted.
REQ-017 In state IDLE, the memory request SHALL be driven combinationally from the ls_* inputs.
REQ-018 adr SHALL equal {ls_adr[AW-1:2], 2'b00}.
REQ-019 Let o = ls_adr[1:0]; sel SHALL be:
- byte: 1<<o
- half: 3<<o
- word: 4'hF<<o
- all truncated to 4 bits.
REQ-020 wdt SHALL be ls_wdt rotated left by 8*o bits.
REQ-021 An access SHALL be split when it crosses a word boundary:
- half with o = 3;
- word with o != 0.
REQ-022 Unsplit access:
- ls_ack = ack;
- FSM stays in IDLE.
REQ-023 Split access, first transfer:
- ls_ack = 0;
- on ack, FSM moves to SPLIT and latches address, size, uns, wen, o and wdt.
REQ-024 Split access, second transfer (SPLIT):
- adr = first address + 4, modulo 2**AW (last word wraps to word 0);
- sel = 4'hF >> (4-o) for word, 4'b0001 for half;
- ls_ack = ack;
- FSM returns to IDLE on ack.
REQ-025 For a split load, the first-transfer rdt SHALL be registered; ls_rdt SHALL merge it with the second-transfer rdt.
REQ-026 ls_vld SHALL assert exactly one cycle after the ls_ack of a load, and never for stores.
REQ-027 ls_rdt SHALL be the addressed bytes right-aligned, extended per ls_uns to DW; it SHALL hold its value while ls_vld = 0.
REQ-028 A new request SHALL be accepted in the same cycle ls_vld is high (back-to-back, no bubble).
REQ-029 While memory ack = 0, the block SHALL hold its state and all latched values, and ls_ack SHALL stay 0.
REQ-030 req SHALL be 0 when ls_req = 0 in IDLE; in SPLIT, req SHALL be 1 regardless of ls_req.

Reset
REQ-031 While rst = 0:
- FSM = IDLE;
- req = 0, ls_ack = 0, ls_vld = 0;
- ls_rdt = 0 and all latched registers = 0.
REQ-032 Reset asserted mid-split SHALL abandon the pending transfer with no later ls_vld; after rst deasserts, the first accepted request SHALL behave as from IDLE.

Structure
REQ-033 Shared package lsu_pkg SHALL hold:
- size enum (SIZ_B, SIZ_H, SIZ_W);
- FSM enum (IDLE, SPLIT).
REQ-034 One sub-module, lsu_ext, SHALL perform the combinational read-data rotate, merge and sign/zero extension; lsu instantiates it once.

Verification
REQ-035 Word store 0x12345678 @0x004, then word load @0x004 -> sel = F, ls_ack in the request cycle, ls_vld next cycle, ls_rdt = 0x12345678.
REQ-036 Memory word @0x008 = 0x80FF7F01:
- byte load @0x00A, uns = 0 -> ls_rdt = 0xFFFFFFFF;
- same with uns = 1 -> 0x000000FF;
- half load @0x009, uns = 0 -> 0xFFFFFF7F.
REQ-037 Word store 0xAABBCCDD @0x00D -> two transfers:
- 1st: adr 0x00C, sel E, wdt 0xBBCCDDxx;
- 2nd: adr 0x010, sel 1, wdt lane0 = 0xAA;
- ls_ack only on the 2nd transfer; reading back gives 0xAABBCCDD.
REQ-038 Word load @0xFFE with mem[0xFFC] = 0x2211xxxx and mem[0x000] = 0xxxxx4433 -> 2nd transfer adr 0x000, ls_rdt = 0x44332211.
REQ-039 Memory ack held 0 for 3 cycles during SPLIT -> latched values hold, no ls_ack, correct result after ack returns; rst pulsed low in SPLIT -> FSM IDLE, req = 0, no ls_vld.
REQ-040 Back-to-back loads @0x000, @0x004, @0x008 on consecutive cycles -> ls_vld high for 3 consecutive cycles with the correct data each cycle.
